// File: rtl/rom_sram_mem_if.sv
// rom_sram_mem_if: access bus between a controller and the unified ROM/SRAM store.
// The controller drives address, write data and the read/write strobe (wr=1 read,
// wr=0 write); the memory returns registered read data and a ROM write error flag.
interface rom_sram_mem_if;
    logic [11:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic [15:0] data_out;
    logic        wr_err;

    modport master (
        output addr,
        output data_in,
        output wr,
        input  data_out,
        input  wr_err
    );

    modport slave (
        input  addr,
        input  data_in,
        input  wr,
        output data_out,
        output wr_err
    );
endinterface

// File: rtl/rom_sram_mem.sv
// rom_sram_mem: 4K x 16 unified store made of one 1K mask ROM (bank 00) and three
// 1K single-port SRAM banks (01, 10, 11). Every cycle is an access with one cycle
// read latency; SRAM writes are write-first.
// Optional feature macro: ROM_WRITE_ERR_EN -- when defined, a write aimed at the ROM
// region raises a one-cycle wr_err aligned with data_out; otherwise wr_err is 0.
module rom_sram_mem (
    input  logic           clk,
    input  logic           rst,
    rom_sram_mem_if.slave  bus
);

    logic [1:0]        w_bankSel;
    logic [9:0]        w_word;
    logic              w_isWrite;
    logic [2:0][15:0]  w_sramQ;
    logic [15:0]       w_dataOut;

    logic [1:0]        r_bankSel;
    logic [15:0]       r_romQ;

    assign w_bankSel = bus.addr[11:10];
    assign w_word    = bus.addr[9:0];
    assign w_isWrite = ~bus.wr;

    // Mask ROM contents; bits [15:14] are always zero and unlisted words read as zero.
    function automatic logic [15:0] romLookup(input logic [9:0] a);
        logic [15:0] v;
        case (a)
            10'd0:   v = 16'h0006;
            10'd1:   v = 16'h0E3F;
            10'd2:   v = 16'h3E79;
            10'd3:   v = 16'h006E;
            10'd4:   v = 16'h1F9C;
            10'd5:   v = 16'h3E00;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Register the bank select alongside the read so the output mux picks the right bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bankSel <= 2'b00;
        end else begin
            r_bankSel <= w_bankSel;
        end
    end

    // ROM read register; cleared by reset so data_out reads zero while reset is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_romQ <= 16'h0000;
        end else if (w_bankSel == 2'b00) begin
            r_romQ <= romLookup(w_word);
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gSram
            logic [15:0] r_mem [0:1023];
            logic [15:0] r_q;
            logic        w_sel;

            assign w_sel = (w_bankSel == 2'(g + 1));

            // Single-port SRAM bank: write-first, reset blocks writes but never clears the array.
            always_ff @(posedge clk) begin
                if (!rst && w_sel) begin
                    if (w_isWrite) begin
                        r_mem[w_word] <= bus.data_in;
                        r_q           <= bus.data_in;
                    end else begin
                        r_q <= r_mem[w_word];
                    end
                end
            end

            assign w_sramQ[g] = r_q;
        end
    endgenerate

    // Output mux steered by the registered bank select so no other bank can leak through.
    always_comb begin
        w_dataOut = r_romQ;
        case (r_bankSel)
            2'b01:   w_dataOut = w_sramQ[0];
            2'b10:   w_dataOut = w_sramQ[1];
            2'b11:   w_dataOut = w_sramQ[2];
            default: w_dataOut = r_romQ;
        endcase
    end

    assign bus.data_out = w_dataOut;

`ifdef ROM_WRITE_ERR_EN
    logic r_wrErr;

    // Flag a write into the ROM region for exactly the cycle its read result is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrErr <= 1'b0;
        end else begin
            r_wrErr <= w_isWrite && (w_bankSel == 2'b00);
        end
    end

    assign bus.wr_err = r_wrErr;
`else
    assign bus.wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_rom_sram_mem.sv
// tb_rom_sram_mem: directed scoreboard bench for rom_sram_mem. Stimulus pushes the
// hand-computed expected result of each access; a monitor pops and compares one
// cycle later, after the DUT has registered the response.
module tb_rom_sram_mem;

    typedef struct {
        logic [15:0] data;
        logic        err;
        string       name;
    } expT;

`ifdef ROM_WRITE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    expT  expQ[$];

    rom_sram_mem_if bus ();

    rom_sram_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one access on the falling edge and record what it must produce.
    task automatic applyStimulus(input logic rstIn, input logic wrIn, input logic [11:0] addrIn,
                                 input logic [15:0] dataIn, input logic [15:0] expData,
                                 input logic expErr, input string name);
        expT e;
        @(negedge clk);
        rst         = rstIn;
        bus.wr      = wrIn;
        bus.addr    = addrIn;
        bus.data_in = dataIn;
        e.data = expData;
        e.err  = expErr;
        e.name = name;
        expQ.push_back(e);
        @(posedge clk);
    endtask

    // Compare one expected entry against the DUT outputs.
    task automatic checkOutput(input expT e);
        checks++;
        if (bus.data_out !== e.data || bus.wr_err !== e.err) begin
            failures++;
            $display("[TB] FAIL %s: data_out=%h wr_err=%b, expected data_out=%h wr_err=%b",
                     e.name, bus.data_out, bus.wr_err, e.data, e.err);
        end
    endtask

    // Monitor: each edge that consumed a queued access has its result checked 1 unit later.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            if (expQ.size() > 0) begin
                #1;
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        logic [15:0] romExp [7];
        int          waitCycles;
        romExp = '{16'h0006, 16'h0E3F, 16'h3E79, 16'h006E, 16'h1F9C, 16'h3E00, 16'h0000};
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 12'h000;
        bus.data_in = 16'h0000;

        applyStimulus(1'b1, 1'b1, 12'h000, 16'h0000, 16'h0000, 1'b0, "reset0");
        applyStimulus(1'b1, 1'b1, 12'h001, 16'h0000, 16'h0000, 1'b0, "reset1");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 12'(i), 16'h0000, romExp[i], 1'b0, $sformatf("romRead%0d", i));
        end

        applyStimulus(1'b0, 1'b0, 12'h400, 16'hA5A5, 16'hA5A5, 1'b0, "wrSram0");
        applyStimulus(1'b0, 1'b0, 12'h800, 16'h5A5A, 16'h5A5A, 1'b0, "wrSram1");
        applyStimulus(1'b0, 1'b0, 12'hC00, 16'h1234, 16'h1234, 1'b0, "wrSram2");
        applyStimulus(1'b0, 1'b1, 12'h400, 16'h0000, 16'hA5A5, 1'b0, "rdSram0");
        applyStimulus(1'b0, 1'b1, 12'h800, 16'h0000, 16'h5A5A, 1'b0, "rdSram1");
        applyStimulus(1'b0, 1'b1, 12'hC00, 16'h0000, 16'h1234, 1'b0, "rdSram2");
        applyStimulus(1'b0, 1'b1, 12'h000, 16'h0000, 16'h0006, 1'b0, "rdRom0");

        applyStimulus(1'b0, 1'b0, 12'h7FF, 16'hBEEF, 16'hBEEF, 1'b0, "writeFirst7FF");
        applyStimulus(1'b0, 1'b1, 12'h7FF, 16'h0000, 16'hBEEF, 1'b0, "readBack7FF");

        applyStimulus(1'b0, 1'b0, 12'hFFF, 16'h0F0F, 16'h0F0F, 1'b0, "writeFirstFFF");
        applyStimulus(1'b0, 1'b1, 12'hC00, 16'h0000, 16'h1234, 1'b0, "rdC00AfterFFF");
        applyStimulus(1'b0, 1'b1, 12'hFFF, 16'h0000, 16'h0F0F, 1'b0, "readBackFFF");

        applyStimulus(1'b0, 1'b0, 12'h002, 16'hFFFF, 16'h3E79, ERR_EN, "romWrite002");
        applyStimulus(1'b0, 1'b1, 12'h002, 16'h0000, 16'h3E79, 1'b0, "romReadAfterWrite");

        applyStimulus(1'b0, 1'b0, 12'h401, 16'h2222, 16'h2222, 1'b0, "preWrite401");
        applyStimulus(1'b1, 1'b0, 12'h401, 16'h1111, 16'h0000, 1'b0, "resetWrite401");
        applyStimulus(1'b0, 1'b1, 12'h401, 16'h0000, 16'h2222, 1'b0, "read401AfterReset");
        applyStimulus(1'b0, 1'b0, 12'h002, 16'h1234, 16'h3E79, ERR_EN, "romWriteAgain");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 12'h3FF, 16'h0000, 16'h0000, 1'b0, $sformatf("switchRom%0d", i));
            applyStimulus(1'b0, 1'b1, 12'h400, 16'h0000, 16'hA5A5, 1'b0, $sformatf("switchSram%0d", i));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        #2;
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
